// File: rtl/uart_rx_queue.sv
// uart_rx_queue
// Serial receive front-end for the RAM1/UART memory path. Notices a byte
// waiting in the external UART chip (data_ready), requests the shared RAM1
// data bus, strobes rdn low to read the byte, then pushes it into a circular
// queue. The memory stage pops bytes from the front of that queue.
//
// Ports:
//   clk, rst          system clock, asynchronous active-low reset
//   data_ready        UART chip has a byte (asynchronous, level)
//   uart_data_in[7:0] low byte of the shared RAM1 data bus
//   bus_req           request for the RAM1 data bus while a read is pending
//   bus_grant         RAM1 bus released to this block
//   rdn               UART read strobe, active-low
//   pop               consume the front byte (one-cycle pulse)
//   front_data[15:0]  {8'b0, front byte}; valid while not_empty
//   not_empty, full   queue status flags
//   front, tail       queue indices (debug)
//   drop_cnt[7:0]     bytes lost to a full queue, saturating
module uart_rx_queue #(
  parameter int DEPTH_LOG2     = 4,
  parameter int RD_CYCLES      = 3,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_ready,
  input  logic [7:0]            uart_data_in,
  output logic                  bus_req,
  input  logic                  bus_grant,
  output logic                  rdn,
  input  logic                  pop,
  output logic [15:0]           front_data,
  output logic                  not_empty,
  output logic                  full,
  output logic [DEPTH_LOG2-1:0] front,
  output logic [DEPTH_LOG2-1:0] tail,
  output logic [7:0]            drop_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int MAXC  = (RD_CYCLES > RECOVER_CYCLES) ? RD_CYCLES : RECOVER_CYCLES;
  localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {
    IDLE, WAIT_GRANT, RD_LOW, CAPTURE, RECOVER
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ds1_q, ds2_q;
  logic [DEPTH_LOG2-1:0] front_q, front_d, tail_q, tail_d, tail_inc;
  logic [7:0]            drop_q, drop_d;
  logic [7:0]            mem_q [DEPTH];
  logic                  push, drop, pop_ok;

  // Two-flop synchroniser; ds2_q is the synchronised data_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ds1_q <= 1'b0;
      ds2_q <= 1'b0;
    end else begin
      ds1_q <= data_ready;
      ds2_q <= ds1_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      front_q <= '0;
      tail_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      front_q <= front_d;
      tail_q  <= tail_d;
      drop_q  <= drop_d;
    end
  end

  // Queue storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= uart_data_in;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    push    = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      IDLE:       if (ds2_q) state_d = WAIT_GRANT;
      WAIT_GRANT: if (bus_grant) begin
                    state_d = RD_LOW;
                    cnt_d   = CW'(RD_CYCLES - 1);
                  end
      // Grant loss from here on is ignored; the read always completes.
      RD_LOW:     if (cnt_q == '0) state_d = CAPTURE;
                  else             cnt_d = cnt_q - 1'b1;
      CAPTURE: begin
        state_d = RECOVER;
        cnt_d   = CW'(RECOVER_CYCLES - 1);
        // full is taken before any same-cycle pop, so an arriving byte is
        // dropped even if a slot frees up on this edge.
        if (full) drop = 1'b1;
        else      push = 1'b1;
      end
      RECOVER:    if (cnt_q == '0) state_d = IDLE;
                  else             cnt_d = cnt_q - 1'b1;
      default:    state_d = IDLE;
    endcase
  end

  assign tail_inc = tail_q + 1'b1;
  assign pop_ok   = pop && not_empty;
  assign tail_d   = push ? tail_inc : tail_q;
  assign front_d  = pop_ok ? front_q + 1'b1 : front_q;
  assign drop_d   = (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;

  // Strobes decode from state alone so an async reset clears them at once.
  assign rdn        = !(state_q == RD_LOW || state_q == CAPTURE);
  assign bus_req    = (state_q == WAIT_GRANT) || (state_q == RD_LOW) ||
                      (state_q == CAPTURE);
  assign not_empty  = (front_q != tail_q);
  assign full       = (tail_inc == front_q);
  assign front_data = {8'h00, mem_q[front_q]};
  assign front      = front_q;
  assign tail       = tail_q;
  assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_uart_rx_queue.sv
module tb_uart_rx_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        data_ready = 1'b0;
  logic [7:0]  uart_data_in = 8'h00;
  logic        bus_req;
  logic        bus_grant = 1'b1;
  logic        rdn;
  logic        pop = 1'b0;
  logic [15:0] front_data;
  logic        not_empty, full;
  logic [3:0]  front, tail;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int fails  = 0;

  uart_rx_queue #(.DEPTH_LOG2(4), .RD_CYCLES(3), .RECOVER_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .data_ready(data_ready), .uart_data_in(uart_data_in),
    .bus_req(bus_req), .bus_grant(bus_grant), .rdn(rdn), .pop(pop),
    .front_data(front_data), .not_empty(not_empty), .full(full),
    .front(front), .tail(tail), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Read one byte through the chip interface; returns rdn-low cycle count.
  // With popcap set, pop is driven during the CAPTURE cycle (4th low cycle).
  task automatic push_byte(input logic [7:0] b, input bit popcap, output int lowcnt);
    int t;
    lowcnt = 0;
    uart_data_in = b;
    data_ready = 1'b1;
    t = 0;
    while (rdn !== 1'b0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (rdn !== 1'b0) chk("rdn_timeout", {31'b0, rdn}, 32'd0);
    data_ready = 1'b0;
    while (rdn === 1'b0 && lowcnt < 20) begin
      lowcnt++;
      if (popcap && lowcnt == 4) pop = 1'b1;
      @(negedge clk);
      pop = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic do_pop();
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
  endtask

  initial begin
    int  lc;
    bit  stall_ok;
    logic [7:0] exp_b;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_rdn", {31'b0, rdn}, 32'd1);
    chk("rst_bus_req", {31'b0, bus_req}, 32'd0);
    chk("rst_not_empty", {31'b0, not_empty}, 32'd0);
    chk("rst_full", {31'b0, full}, 32'd0);
    chk("rst_front", {28'b0, front}, 32'd0);
    chk("rst_tail", {28'b0, tail}, 32'd0);
    chk("rst_drop", {24'b0, drop_cnt}, 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_bus_req", {31'b0, bus_req}, 32'd0);

    // single byte
    push_byte(8'h5A, 1'b0, lc);
    chk("single_rdn_low", lc, 32'd4);
    chk("single_tail", {28'b0, tail}, 32'd1);
    chk("single_not_empty", {31'b0, not_empty}, 32'd1);
    chk("single_data", {16'b0, front_data}, 32'h005A);
    do_pop();
    chk("single_pop_front", {28'b0, front}, 32'd1);
    chk("single_pop_empty", {31'b0, not_empty}, 32'd0);

    // grant stall
    do_reset();
    bus_grant = 1'b0;
    uart_data_in = 8'h33;
    data_ready = 1'b1;
    repeat (4) @(negedge clk);
    stall_ok = 1'b1;
    repeat (10) begin
      if (bus_req !== 1'b1 || rdn !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
    end
    chk("stall_hold", {31'b0, stall_ok}, 32'd1);
    bus_grant = 1'b1;
    @(negedge clk);
    chk("stall_rdn_fall", {31'b0, rdn}, 32'd0);
    data_ready = 1'b0;
    repeat (10) @(negedge clk);
    chk("stall_data", {16'b0, front_data}, 32'h0033);

    // fill and overflow
    do_reset();
    for (int i = 1; i <= 15; i++) push_byte(8'(i), 1'b0, lc);
    chk("fill_full", {31'b0, full}, 32'd1);
    chk("fill_tail", {28'b0, tail}, 32'd15);
    push_byte(8'hFF, 1'b0, lc);
    chk("ovf_drop", {24'b0, drop_cnt}, 32'd1);
    chk("ovf_tail", {28'b0, tail}, 32'd15);
    for (int i = 1; i <= 15; i++) begin
      chk($sformatf("drain_%0d", i), {16'b0, front_data}, 32'(i));
      do_pop();
    end
    chk("drain_empty", {31'b0, not_empty}, 32'd0);
    chk("drain_full", {31'b0, full}, 32'd0);

    // wrap plus simultaneous push/pop
    do_reset();
    for (int i = 0; i < 10; i++) push_byte(8'h10 + 8'(i), 1'b0, lc);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("wrapA_%0d", i), {16'b0, front_data}, 32'h10 + 32'(i));
      do_pop();
    end
    for (int i = 0; i < 8; i++) push_byte(8'h20 + 8'(i), 1'b0, lc);
    chk("wrap_tail", {28'b0, tail}, 32'd2);
    chk("wrap_front", {28'b0, front}, 32'd10);
    chk("wrap_head", {16'b0, front_data}, 32'h0020);
    push_byte(8'h30, 1'b1, lc);
    chk("simul_front", {28'b0, front}, 32'd11);
    chk("simul_tail", {28'b0, tail}, 32'd3);
    for (int i = 1; i <= 8; i++) begin
      exp_b = (i == 8) ? 8'h30 : 8'h20 + 8'(i);
      chk($sformatf("wrapB_%0d", i), {16'b0, front_data}, {24'b0, exp_b});
      do_pop();
    end
    chk("wrap_empty", {31'b0, not_empty}, 32'd0);

    // reset mid-read
    do_reset();
    uart_data_in = 8'h77;
    data_ready = 1'b1;
    for (int t = 0; t < 60 && rdn !== 1'b0; t++) @(negedge clk);
    chk("mid_rdlow", {31'b0, rdn}, 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_rdn", {31'b0, rdn}, 32'd1);
    chk("mid_rst_bus_req", {31'b0, bus_req}, 32'd0);
    chk("mid_rst_empty", {31'b0, not_empty}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    push_byte(8'h77, 1'b0, lc);
    chk("mid_reread_tail", {28'b0, tail}, 32'd1);
    chk("mid_reread_front", {28'b0, front}, 32'd0);
    chk("mid_reread_data", {16'b0, front_data}, 32'h0077);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
